// File: rtl/bin2bcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - state_e      : FSM state encoding (IDLE, SHIFT, DONE)
//   - DEFAULT_DIGITS : default number of BCD digits
//   - max_value()  : 10^digits - 1, the largest displayable value
//   - MAX_VALUE    : max_value(DEFAULT_DIGITS)
//   - ALL_NINES    : saturation pattern shown on overflow at the default width
// -----------------------------------------------------------------------------
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_DIGITS = 4;

  // Largest value representable with 'digits' decimal digits.
  function automatic longint unsigned max_value(input int digits);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam longint unsigned MAX_VALUE = max_value(DEFAULT_DIGITS);

  localparam logic [4*DEFAULT_DIGITS-1:0] ALL_NINES = {DEFAULT_DIGITS{4'h9}};

endpackage : bin2bcd_seq_pkg

// File: rtl/bin2bcd_seq_bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more, so
// that the following left shift carries correctly into the next digit.
// Ports:
//   digit  in  4 : scratch digit before the shift
//   adj    out 4 : corrected digit
// Purely combinational.
// -----------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  // Add-3 correction for digits >= 5.
  always_comb begin
    if (digit >= 4'd5) begin
      adj = digit + 4'd3;
    end else begin
      adj = digit;
    end
  end

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Feeds the per-digit 7-segment decoders; bcd only changes in the done cycle
// or on reset, so the display never sees intermediate scratch values.
// Parameters:
//   W       : binary input width (<= 64)
//   DIGITS  : number of BCD digits produced
// Ports:
//   clk       in  1         : clock, rising edge
//   reset     in  1         : synchronous, active-high
//   start     in  1         : conversion request, sampled while busy = 0
//   valor     in  W         : binary value, captured when start is accepted
//   busy      out 1         : conversion in progress
//   done      out 1         : one-cycle pulse, bcd/overflow updated this cycle
//   bcd       out 4*DIGITS  : result digits, digit 0 (units) in [3:0]
//   overflow  out 1         : last value exceeded 10^DIGITS - 1 (bcd = all 9s)
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int W      = 14,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          valor,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  localparam longint unsigned   MAX_VAL  = max_value(DIGITS);
  localparam logic [SW-1:0]     NINES    = {DIGITS{4'h9}};
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  // Counter value during the final (W-th) shift iteration.
  localparam logic [CW-1:0]     CNT_LAST = CW'(W - 1);

  // Registered state
  state_e            state_r,   state_nxt_s;
  logic [W-1:0]      bin_r,     bin_nxt_s;
  logic [SW-1:0]     scratch_r, scratch_nxt_s;
  logic [CW-1:0]     cnt_r,     cnt_nxt_s;
  logic              flag_r,    flag_nxt_s;
  logic              busy_r,    busy_nxt_s;
  logic              done_r,    done_nxt_s;
  logic [SW-1:0]     bcd_r,     bcd_nxt_s;
  logic              ovf_r,     ovf_nxt_s;

  // Datapath
  logic [SW-1:0]     scratch_adj_s;
  logic [SW-1:0]     scratch_shift_s;
  logic [W-1:0]      bin_shift_s;
  logic              valor_ovf_s;

  // One add-3 corrector per scratch digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit (scratch_r[4*g +: 4]),
      .adj   (scratch_adj_s[4*g +: 4])
    );
  end

  // Shift {scratch, binary} left by one; the carry out of the top digit is
  // dropped, which only happens for values already flagged as overflow.
  always_comb begin
    scratch_shift_s = {scratch_adj_s[SW-2:0], bin_r[W-1]};
    bin_shift_s     = {bin_r[W-2:0], 1'b0};
    valor_ovf_s     = (64'(valor) > MAX_VAL);
  end

  // Next-state and next-register logic for the converter FSM.
  always_comb begin
    state_nxt_s   = state_r;
    bin_nxt_s     = bin_r;
    scratch_nxt_s = scratch_r;
    cnt_nxt_s     = cnt_r;
    flag_nxt_s    = flag_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    bcd_nxt_s     = bcd_r;
    ovf_nxt_s     = ovf_r;

    case (state_r)
      IDLE, DONE: begin
        // DONE accepts start too, giving back-to-back conversions every W+1.
        if (start) begin
          state_nxt_s   = SHIFT;
          bin_nxt_s     = valor;
          scratch_nxt_s = {SW{1'b0}};
          cnt_nxt_s     = {CW{1'b0}};
          flag_nxt_s    = valor_ovf_s;
          busy_nxt_s    = 1'b1;
        end else begin
          state_nxt_s   = IDLE;
          busy_nxt_s    = 1'b0;
        end
      end

      SHIFT: begin
        scratch_nxt_s = scratch_shift_s;
        bin_nxt_s     = bin_shift_s;
        cnt_nxt_s     = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          // Last shift: the result lands in bcd on the same edge so it is
          // valid together with done.
          state_nxt_s = DONE;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
          ovf_nxt_s   = flag_r;
          if (flag_r) begin
            bcd_nxt_s = NINES;
          end else begin
            bcd_nxt_s = scratch_shift_s;
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end

      default: begin
        state_nxt_s = IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      bin_r     <= {W{1'b0}};
      scratch_r <= {SW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      flag_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bcd_r     <= {SW{1'b0}};
      ovf_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bin_r     <= bin_nxt_s;
      scratch_r <= scratch_nxt_s;
      cnt_r     <= cnt_nxt_s;
      flag_r    <= flag_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      bcd_r     <= bcd_nxt_s;
      ovf_r     <= ovf_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign bcd      = bcd_r;
  assign overflow = ovf_r;

endmodule : bin2bcd_seq
